// File: rtl/uncache_store_queue_pkg.sv
// Shared types for the uncached posted-write queue: FSM encoding, SRAM-like
// size codes and the packed store-entry record held in the FIFO.
package uncache_store_queue_pkg;

    // Downstream activity of the queue.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DRAIN_WAIT = 2'd1,
        ST_LOAD_WAIT  = 2'd2
    } sq_state_e;

    // SRAM-like access size encodings.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Default datapath widths of the uncached port.
    localparam int SQ_ADDR_W = 32;
    localparam int SQ_DATA_W = 32;

    // One posted store at the default widths; field order matches the packing
    // used by the top level, so the flat entry can be cast to this record.
    typedef struct packed {
        logic [SQ_ADDR_W-1:0]   addr;
        logic [1:0]             size;
        logic [SQ_DATA_W-1:0]   wdata;
        logic [SQ_DATA_W/8-1:0] wstrb;
    } sq_entry_t;

    // Flat width of a store entry {addr, size, wdata, wstrb} for any widths.
    function automatic int sq_entry_width(input int addr_w, input int data_w);
        return addr_w + 2 + data_w + (data_w / 8);
    endfunction

endpackage

// File: rtl/uncache_store_queue_fifo.sv
// Generic circular FIFO: DEPTH entries of WIDTH bits, power-of-two depth so
// the pointers wrap naturally. Push is ignored when full, pop when empty.
module uncache_store_queue_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o      = (count_q == FULL_CNT);
    assign empty_o     = (count_q == {(PTR_W + 1){1'b0}});
    assign count_o     = count_q;
    assign head_data_o = mem_q[head_q];
    assign do_push_s   = push_i & ~full_o;
    assign do_pop_s    = pop_i & ~empty_o;

    // Pointer and occupancy next-state; simultaneous push and pop keep count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push_s) begin
            tail_d = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (do_pop_s) begin
            head_d = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {(PTR_W + 1){1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, written at the tail; contents are not reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uncache_store_queue.sv
// In-order posted-write queue on the uncached path. Stores are acked early
// and drained one at a time; loads wait until the queue is fully drained so
// MMIO ordering is preserved.
module uncache_store_queue
    import uncache_store_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_wr,
    input  logic [1:0]              cpu_size,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [DATA_W-1:0]       cpu_wdata,
    input  logic [DATA_W/8-1:0]     cpu_wstrb,
    output logic [DATA_W-1:0]       cpu_rdata,
    output logic                    cpu_addr_ok,
    output logic                    cpu_data_ok,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [1:0]              mem_size,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_wstrb,
    input  logic [DATA_W-1:0]       mem_rdata,
    input  logic                    mem_addr_ok,
    input  logic                    mem_data_ok,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drained,
    output logic [CNT_W-1:0]        full_stall_cnt
);

    localparam int STRB_W  = DATA_W / 8;
    localparam int ENTRY_W = sq_entry_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

    sq_state_e          state_q, state_d;
    logic               ack_q, ack_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic [ENTRY_W-1:0] push_entry_s, head_entry_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [1:0]         head_size_s;
    logic [DATA_W-1:0]  head_wdata_s;
    logic [STRB_W-1:0]  head_wstrb_s;
    logic               fifo_full_s, fifo_empty_s;
    logic               in_idle_s, in_load_wait_s;
    logic               push_s, pop_s, drain_issue_s, load_ok_s, stall_evt_s;

    assign push_entry_s = {cpu_addr, cpu_size, cpu_wdata, cpu_wstrb};
    assign {head_addr_s, head_size_s, head_wdata_s, head_wstrb_s} = head_entry_s;

    assign in_idle_s      = (state_q == ST_IDLE);
    assign in_load_wait_s = (state_q == ST_LOAD_WAIT);

    // Stores are refused during a load so CPU responses stay in order.
    assign push_s        = cpu_req & cpu_wr & ~fifo_full_s & ~in_load_wait_s;
    assign drain_issue_s = in_idle_s & ~fifo_empty_s;
    assign pop_s         = drain_issue_s & mem_addr_ok;
    assign load_ok_s     = in_idle_s & fifo_empty_s & cpu_req & ~cpu_wr;
    assign stall_evt_s   = cpu_req & cpu_wr & fifo_full_s;

    assign drained        = fifo_empty_s & in_idle_s;
    assign full_stall_cnt = stall_cnt_q;

    uncache_store_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_data_o (head_entry_s),
        .count_o     (count),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // FSM next state: one downstream transaction in flight at a time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_DRAIN_WAIT;
                end else if (load_ok_s && mem_addr_ok) begin
                    state_d = ST_LOAD_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN_WAIT: begin
                if (mem_data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (mem_data_ok) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Downstream port: queued head store has priority, else pass-through load.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_wstrb = {STRB_W{1'b0}};
        if (drain_issue_s) begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_size  = head_size_s;
            mem_addr  = head_addr_s;
            mem_wdata = head_wdata_s;
            mem_wstrb = head_wstrb_s;
        end else if (load_ok_s) begin
            mem_req   = cpu_req;
            mem_wr    = cpu_wr;
            mem_size  = cpu_size;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wstrb = cpu_wstrb;
        end else begin
            mem_req   = 1'b0;
        end
    end

    // CPU port: early store ack via the flop, load response straight through.
    always_comb begin
        cpu_addr_ok = push_s | (load_ok_s & mem_addr_ok);
        cpu_data_ok = ack_q | (in_load_wait_s & mem_data_ok);
        if (in_load_wait_s) begin
            cpu_rdata = mem_rdata;
        end else begin
            cpu_rdata = {DATA_W{1'b0}};
        end
    end

    // Store-ack and saturating full-stall counter next state.
    always_comb begin
        ack_d = push_s;
        if (stall_evt_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Control registers; reset discards any outstanding transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_uncache_store_queue.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model of the posted-write rules.
module tb_uncache_store_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_wr;
    logic [1:0]        cpu_size;
    logic [31:0]       cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_addr_ok, cpu_data_ok;
    logic              mem_req, mem_wr;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [3:0]        mem_wstrb;
    logic              mem_addr_ok, mem_data_ok;
    logic [3:0]        count;
    logic              drained;
    logic [CNT_W-1:0]  full_stall_cnt;

    always #5 clk = ~clk;

    uncache_store_queue #(
        .DEPTH (DEPTH), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .rst (rst),
        .cpu_req (cpu_req), .cpu_wr (cpu_wr), .cpu_size (cpu_size),
        .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata), .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata), .cpu_addr_ok (cpu_addr_ok), .cpu_data_ok (cpu_data_ok),
        .mem_req (mem_req), .mem_wr (mem_wr), .mem_size (mem_size),
        .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata), .mem_addr_ok (mem_addr_ok), .mem_data_ok (mem_data_ok),
        .count (count), .drained (drained), .full_stall_cnt (full_stall_cnt)
    );

    // Reference model: pending stores, what is outstanding downstream
    // (0 nothing, 1 a store, 2 a load), a pending early ack, stall count.
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } ent_t;

    ent_t mq[$];
    int   kind;
    bit   ack_pend;
    int   stall;
    bit   last_acc;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] sz);
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        cpu_wstrb = s; cpu_size = sz;
    endtask

    task automatic cpu_load(input logic [31:0] a, input logic [1:0] sz);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = a; cpu_size = sz;
        cpu_wdata = $urandom; cpu_wstrb = 4'h0;
    endtask

    // One clock: compare all outputs against the model, advance the model.
    task automatic cycle();
        bit full, e_push, e_drain, e_load, e_acc, e_dok;
        #1;
        if (rst) begin
            mq.delete(); kind = 0; ack_pend = 1'b0; stall = 0; last_acc = 1'b0;
        end else begin
            full    = (mq.size() == DEPTH);
            e_push  = cpu_req && cpu_wr && !full && (kind != 2);
            e_drain = (kind == 0) && (mq.size() != 0);
            e_load  = (kind == 0) && (mq.size() == 0) && cpu_req && !cpu_wr;
            e_acc   = e_push || (e_load && mem_addr_ok);
            e_dok   = ack_pend || ((kind == 2) && mem_data_ok);
            check_eq("addr_ok", 64'(cpu_addr_ok), 64'(e_acc));
            check_eq("data_ok", 64'(cpu_data_ok), 64'(e_dok));
            if ((kind == 2) && mem_data_ok) check_eq("rdata", 64'(cpu_rdata), 64'(mem_rdata));
            check_eq("mem_req", 64'(mem_req), 64'(e_drain || e_load));
            if (e_drain) begin
                check_eq("drain_wr",    64'(mem_wr),    64'(1));
                check_eq("drain_addr",  64'(mem_addr),  64'(mq[0].addr));
                check_eq("drain_size",  64'(mem_size),  64'(mq[0].size));
                check_eq("drain_wdata", 64'(mem_wdata), 64'(mq[0].wdata));
                check_eq("drain_wstrb", 64'(mem_wstrb), 64'(mq[0].wstrb));
            end else if (e_load) begin
                check_eq("load_wr",   64'(mem_wr),   64'(0));
                check_eq("load_addr", 64'(mem_addr), 64'(cpu_addr));
                check_eq("load_size", 64'(mem_size), 64'(cpu_size));
            end
            check_eq("count",   64'(count),          64'(mq.size()));
            check_eq("drained", 64'(drained),        64'((mq.size() == 0) && (kind == 0)));
            check_eq("stall",   64'(full_stall_cnt), 64'(stall));
            if (cpu_req && cpu_wr && full && (stall < (1 << CNT_W) - 1)) stall++;
            ack_pend = e_push;
            if ((kind != 0) && mem_data_ok) kind = 0;
            if (e_drain && mem_addr_ok) begin
                void'(mq.pop_front());
                kind = 1;
            end
            if (e_load && mem_addr_ok) kind = 2;
            if (e_push) mq.push_back(ent_t'{cpu_addr, cpu_size, cpu_wdata, cpu_wstrb});
            last_acc = e_acc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Let memory accept and answer everything until queue and CPU are idle.
    task automatic drain_all();
        int n = 0;
        mem_addr_ok = 1'b1;
        while ((mq.size() != 0 || kind != 0 || cpu_req) && n < 300) begin
            mem_data_ok = (kind != 0);
            mem_rdata   = $urandom;
            cycle();
            if (last_acc) cpu_req = 1'b0;
            n++;
        end
        check_eq("drain_timeout", 64'(n < 300), 64'(1));
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    initial begin
        int refused;
        int n;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_size = 2'd0; cpu_addr = 32'h0;
        cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        kind = 0; ack_pend = 1'b0; stall = 0; last_acc = 1'b0;
        @(negedge clk);
        cycle(); cycle();
        rst = 1'b0;
        #1;
        check_eq("rst_count",   64'(count),          64'(0));
        check_eq("rst_drained", 64'(drained),        64'(1));
        check_eq("rst_mem_req", 64'(mem_req),        64'(0));
        check_eq("rst_data_ok", 64'(cpu_data_ok),    64'(0));
        check_eq("rst_stall",   64'(full_stall_cnt), 64'(0));

        // Scenario 1: single store, early ack, drain the cycle after.
        cpu_store(32'hBFAF_F000, 32'h1234_5678, 4'hF, 2'd2);
        cycle();
        check_eq("s1_acc", 64'(last_acc), 64'(1));
        cpu_req = 1'b0; mem_addr_ok = 1'b1;
        #1;
        check_eq("s1_ack",   64'(cpu_data_ok), 64'(1));
        check_eq("s1_maddr", 64'(mem_addr),    64'(32'hBFAF_F000));
        check_eq("s1_mdata", 64'(mem_wdata),   64'(32'h1234_5678));
        cycle();
        check_eq("s1_count0", 64'(count),   64'(0));
        check_eq("s1_busy",   64'(drained), 64'(0));
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cycle();
        mem_data_ok = 1'b0;
        check_eq("s1_drained", 64'(drained), 64'(1));

        // Scenario 2: fill, stall on full until saturation, then drain in order.
        for (int i = 0; i < 8; i++) begin
            cpu_store(32'h1000_0000 + 32'(i * 4), $urandom, 4'hF, 2'd2);
            cycle();
        end
        check_eq("s2_count8", 64'(count), 64'(8));
        cpu_store(32'h1000_0020, 32'hCAFE_0009, 4'h3, 2'd1);
        repeat (3) cycle();
        check_eq("s2_stall3", 64'(full_stall_cnt), 64'(3));
        repeat (15) cycle();
        check_eq("s2_stall_sat", 64'(full_stall_cnt), 64'(15));
        drain_all();

        // Scenario 3: load held behind a queued store.
        cpu_store(32'hBFAF_F000, $urandom, 4'hF, 2'd2);
        mem_addr_ok = 1'b1;
        cycle();
        cpu_load(32'hBFAF_F004, 2'd2);
        refused = 0; n = 0;
        do begin
            mem_data_ok = (kind != 0);
            cycle();
            if (!last_acc) refused++;
            n++;
        end while (!last_acc && n < 20);
        check_eq("s3_hold", 64'(refused), 64'(2));
        cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("s3_rdata",   64'(cpu_rdata),   64'(32'hDEAD_BEEF));
        check_eq("s3_data_ok", 64'(cpu_data_ok), 64'(1));
        cycle();
        mem_data_ok = 1'b0;

        // Scenario 4: store refused while a load is outstanding.
        cpu_load(32'hBFAF_F008, 2'd2);
        mem_addr_ok = 1'b1;
        cycle();
        check_eq("s4_load_acc", 64'(last_acc), 64'(1));
        cpu_store(32'hBFAF_F00C, $urandom, 4'hF, 2'd2);
        mem_addr_ok = 1'b0;
        refused = 0;
        repeat (3) begin
            cycle();
            if (!last_acc) refused++;
        end
        mem_data_ok = 1'b1; mem_rdata = $urandom;
        cycle();
        if (!last_acc) refused++;
        mem_data_ok = 1'b0;
        cycle();
        check_eq("s4_store_acc", 64'(last_acc), 64'(1));
        check_eq("s4_refused",   64'(refused),  64'(4));
        cpu_req = 1'b0;
        drain_all();

        // Scenario 5: push and pop in the same cycle at count 7.
        for (int i = 0; i < 7; i++) begin
            cpu_store(32'h2000_0000 + 32'(i * 4), $urandom, 4'(i + 1), 2'd2);
            cycle();
        end
        check_eq("s5_count7a", 64'(count), 64'(7));
        cpu_store(32'h2000_001C, $urandom, 4'hF, 2'd2);
        mem_addr_ok = 1'b1;
        cycle();
        check_eq("s5_acc",     64'(last_acc), 64'(1));
        check_eq("s5_count7b", 64'(count),    64'(7));
        cpu_req = 1'b0;
        drain_all();

        // Scenario 6: reset while draining with five entries queued.
        for (int i = 0; i < 6; i++) begin
            cpu_store(32'h3000_0000 + 32'(i * 4), $urandom, 4'hF, 2'd2);
            cycle();
        end
        cpu_req = 1'b0; mem_addr_ok = 1'b1;
        cycle();
        mem_addr_ok = 1'b0;
        check_eq("s6_count5", 64'(count), 64'(5));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check_eq("s6_count0",  64'(count),       64'(0));
        check_eq("s6_drained", 64'(drained),     64'(1));
        check_eq("s6_mem_req", 64'(mem_req),     64'(0));
        check_eq("s6_data_ok", 64'(cpu_data_ok), 64'(0));
        cpu_store(32'hBFAF_F000, 32'h1234_5678, 4'hF, 2'd2);
        cycle();
        check_eq("s6_acc", 64'(last_acc), 64'(1));
        cpu_req = 1'b0; mem_addr_ok = 1'b1;
        cycle();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        cycle();
        mem_data_ok = 1'b0;
        check_eq("s6_drained2", 64'(drained), 64'(1));

        // Random traffic with periodic downstream back-pressure.
        for (int c = 0; c < 1500; c++) begin
            if (!cpu_req && $urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 3) == 0)
                    cpu_load($urandom & 32'hFFFF_FFFC, 2'($urandom_range(0, 2)));
                else
                    cpu_store($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 2'($urandom_range(0, 2)));
            end
            mem_addr_ok = ((c % 200) < 60) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_data_ok = (kind != 0) && ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;
            cycle();
            if (last_acc) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        drain_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uncache_store_queue.md
Name: uncache_store_queue

Overview:
- Parametrised, in-order posted-write queue on the uncached data path, between the CPU data SRAM-like port and the uncached AXI bridge port.
- Stores are accepted into a DEPTH-entry FIFO and acknowledged early; the queue then drains them one transaction at a time.
- Loads are strictly ordered behind all queued stores (MMIO-safe) and pass through only when the queue is fully drained.
- Adds a per-entry size field, an occupancy count, a drained indication and a full-stall performance counter.

Parameters:
DEPTH, 8, number of queue entries; power of two, minimum 2
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
CNT_W, 32, width of the full-stall performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU request valid
cpu_wr  in  1  1 = store, 0 = load
cpu_size  in  2  access size
cpu_addr  in  ADDR_W  access address
cpu_wdata  in  DATA_W  store data
cpu_wstrb  in  DATA_W/8  store byte strobes
cpu_rdata  out  DATA_W  load data
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  response valid this cycle
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream store/load
mem_size  out  2  downstream access size
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream store data
mem_wstrb  out  DATA_W/8  downstream byte strobes
mem_rdata  in  DATA_W  downstream load data
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response
count  out  clog2(DEPTH)+1  current occupancy
drained  out  1  queue empty and no downstream transaction outstanding
full_stall_cnt  out  CNT_W  cycles in which a store was presented while the queue was full

Behaviour:
- Reset: head, tail and count go to 0; state goes to IDLE; store-ack flop, cpu_data_ok, cpu_addr_ok, mem_req and full_stall_cnt all go to 0; drained goes to 1. Entry storage is not reset. Reset mid-transaction discards every entry and any outstanding transaction.
- FSM states:
  - IDLE: no downstream transaction in flight.
  - DRAIN_WAIT: queued store issued, awaiting mem_data_ok.
  - LOAD_WAIT: pass-through load issued, awaiting mem_data_ok.
- Store push: push = cpu_req & cpu_wr & (count != DEPTH) & (state != LOAD_WAIT).
  - cpu_addr_ok = push in the same cycle (combinational).
  - {addr, size, wdata, wstrb} are written at the tail; tail wraps modulo DEPTH.
  - cpu_data_ok pulses exactly one cycle later through a registered ack, with rdata don't-care.
  - There is no bypass: a store pushed into an empty queue issues downstream no earlier than the next cycle.
- Drain:
  - In IDLE with count != 0, drive mem_req=1, mem_wr=1 and the head entry's fields.
  - On mem_addr_ok: pop the head (head wraps modulo DEPTH) and go to DRAIN_WAIT.
  - On mem_data_ok: go to IDLE. This data_ok is never forwarded to the CPU.
  - Back-to-back drains are spaced by at least one IDLE cycle.
- Load:
  - Allowed only when state == IDLE and count == 0 and no push occurs in the same cycle (the load rule already excludes push because cpu_wr=0).
  - Then mem_req=cpu_req and all mem fields come straight from the cpu side.
  - cpu_addr_ok = mem_addr_ok; on that handshake go to LOAD_WAIT.
  - In LOAD_WAIT: cpu_data_ok = mem_data_ok and cpu_rdata = mem_rdata; on mem_data_ok go to IDLE.
  - A load presented while the queue is non-empty or busy gets cpu_addr_ok=0 and stalls until the queue is drained.
- Stores during LOAD_WAIT are refused (cpu_addr_ok=0), so CPU responses stay in order.
- Registered store ack and load data_ok can never coincide: a push is impossible in LOAD_WAIT.
- count: push and pop in the same cycle leave it unchanged; otherwise +1 or -1. count never exceeds DEPTH and never underflows. Full = (count == DEPTH).
- drained = (count == 0) & (state == IDLE).
- full_stall_cnt increments when cpu_req & cpu_wr & full, and saturates at all-ones.
- mem_req is 0 whenever none of the above conditions holds.

Decomposition:
- Shared package: FSM state encoding {IDLE, DRAIN_WAIT, LOAD_WAIT}, the SRAM-like size encodings, and a packed store-entry record {addr, size, wdata, wstrb}.
- Natural sub-module: sq_fifo. A generic DEPTH×entry circular FIFO with push, pop, head data, count, full and empty. The top level holds the FSM, the port muxing and the performance counter.

Test Plan:
1. Single store 0xBFAF_F000/0x1234_5678/wstrb 0xF → cpu_addr_ok same cycle, cpu_data_ok next cycle; mem_req the cycle after push carries the same fields; count goes 1→0 at mem_addr_ok; drained=1 after mem_data_ok.
2. Eight stores back-to-back with mem_addr_ok held low → all accepted and count=8; a ninth store gets cpu_addr_ok=0 and full_stall_cnt increments each cycle it is held. Release mem → entries drain in order 0..7 with tail/head wrap exercised.
3. Store, then an immediate load to 0xBFAF_F004 → load is held (cpu_addr_ok=0) until the store's mem_data_ok; load then issues downstream and returns mem_rdata 0xDEAD_BEEF via cpu_data_ok.
4. Load outstanding (LOAD_WAIT) while a store is presented → store cpu_addr_ok=0 until load data_ok; exactly one cpu_data_ok per request, in order.
5. Queue at count=7 with a push and a pop (mem_addr_ok) in the same cycle → count stays 7 and no entry is lost or duplicated.
6. Assert rst with count=5 while in DRAIN_WAIT → next cycle count=0, drained=1, mem_req=0, no cpu_data_ok; a new store afterwards behaves as in scenario 1.
